// File: rtl/sync_to_pattern.sv
// Recovers pixel column/row from VGA H/V sync pulses and emits a selectable RGB test
// pattern with the syncs re-timed to match. Build macro TP_MOVING_BAR_EN enables the moving bar on pattern 7.
module sync_to_pattern #(
  parameter int unsigned ACTIVE_COLS = 640,
  parameter int unsigned ACTIVE_ROWS = 480,
  parameter int unsigned TOTAL_COLS  = 800,
  parameter int unsigned TOTAL_ROWS  = 525,
  parameter int unsigned VIDEO_WIDTH = 3,
  parameter int unsigned CHECK_SHIFT = 5
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   i_H_Sync,
  input  logic                   i_V_Sync,
  input  logic [2:0]             i_Pattern,
  output logic                   o_H_Sync,
  output logic                   o_V_Sync,
  output logic                   o_Active,
  output logic [9:0]             o_Col_Count,
  output logic [9:0]             o_Row_Count,
  output logic [VIDEO_WIDTH-1:0] o_Red,
  output logic [VIDEO_WIDTH-1:0] o_Grn,
  output logic [VIDEO_WIDTH-1:0] o_Blu
);

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned BAR_W   = ACTIVE_COLS / 8;

  localparam logic [CNT_W-1:0] LP_ACT_COLS     = CNT_W'(ACTIVE_COLS);
  localparam logic [CNT_W-1:0] LP_ACT_ROWS     = CNT_W'(ACTIVE_ROWS);
  localparam logic [CNT_W-1:0] LP_LAST_ACT_COL = CNT_W'(ACTIVE_COLS - 1);
  localparam logic [CNT_W-1:0] LP_LAST_ACT_ROW = CNT_W'(ACTIVE_ROWS - 1);
  localparam logic [CNT_W-1:0] LP_LAST_COL     = CNT_W'(TOTAL_COLS - 1);
  localparam logic [CNT_W-1:0] LP_LAST_ROW     = CNT_W'(TOTAL_ROWS - 1);

  typedef enum logic [2:0] {
    PAT_BLACK  = 3'd0,
    PAT_RED    = 3'd1,
    PAT_GREEN  = 3'd2,
    PAT_BLUE   = 3'd3,
    PAT_CHECK  = 3'd4,
    PAT_BARS   = 3'd5,
    PAT_BORDER = 3'd6,
    PAT_BAR    = 3'd7
  } pattern_e;

  logic             r_h_hist;
  logic             r_v_hist;
  logic             r_h_out;
  logic             r_v_out;
  logic [CNT_W-1:0] r_col;
  logic [CNT_W-1:0] r_row;
  pattern_e         r_pattern;

  logic                   r_active;
  logic [VIDEO_WIDTH-1:0] r_red;
  logic [VIDEO_WIDTH-1:0] r_grn;
  logic [VIDEO_WIDTH-1:0] r_blu;

  logic             w_h_edge;
  logic             w_v_edge;
  logic             w_line_start;
  logic [CNT_W-1:0] w_col_next;
  logic [CNT_W-1:0] w_row_next;
  logic [CNT_W-1:0] w_row_inc;
  logic             w_in_active;
  logic [2:0]       w_bar_idx;
  logic [2:0]       w_rgb;

  assign w_h_edge = i_H_Sync & ~r_h_hist;
  assign w_v_edge = i_V_Sync & ~r_v_hist;

  // Next counter values: sync edges realign, otherwise free-run with wrap.
  always_comb begin : p_next_count
    w_line_start = w_h_edge || (r_col == LP_LAST_COL);
    w_row_inc    = (r_row == LP_LAST_ROW) ? '0 : r_row + CNT_W'(1);
    w_col_next   = w_line_start ? '0 : r_col + CNT_W'(1);
    w_row_next   = r_row;
    if (w_v_edge) begin
      w_row_next = '0;
    end else if (w_line_start) begin
      w_row_next = w_row_inc;
    end
  end

  // Stage 1: sync history, recovered counters, per-frame pattern latch.
  always_ff @(posedge CLK or posedge RST) begin : p_stage1
    if (RST) begin
      r_h_hist  <= 1'b1;
      r_v_hist  <= 1'b1;
      r_h_out   <= 1'b1;
      r_v_out   <= 1'b1;
      r_col     <= '0;
      r_row     <= '0;
      r_pattern <= PAT_BLACK;
    end else begin
      r_h_hist <= i_H_Sync;
      r_v_hist <= i_V_Sync;
      r_h_out  <= r_h_hist;
      r_v_out  <= r_v_hist;
      r_col    <= w_col_next;
      r_row    <= w_row_next;
      if (w_v_edge) begin
        r_pattern <= pattern_e'(i_Pattern);
      end
    end
  end

`ifdef TP_MOVING_BAR_EN
  localparam int unsigned BAR_CMP_W = CNT_W + 1;

  logic [CNT_W-1:0]     r_bar_pos;
  logic [BAR_CMP_W-1:0] w_bar_end;
  logic                 w_bar_hit;

  assign w_bar_end = {1'b0, r_bar_pos} + BAR_CMP_W'(8);
  assign w_bar_hit = (r_col >= r_bar_pos) && ({1'b0, r_col} < w_bar_end);

  // Bar steps one width per frame and restarts once it would leave the active area.
  always_ff @(posedge CLK or posedge RST) begin : p_bar_pos
    if (RST) begin
      r_bar_pos <= '0;
    end else if (w_v_edge) begin
      r_bar_pos <= (w_bar_end >= BAR_CMP_W'(ACTIVE_COLS)) ? '0 : w_bar_end[CNT_W-1:0];
    end
  end
`endif

  // Pixel colour as an {R,G,B} on/off mask from the stage-1 counters.
  always_comb begin : p_pixel
    w_in_active = (r_col < LP_ACT_COLS) && (r_row < LP_ACT_ROWS);
    w_bar_idx   = '0;
    for (int k = 1; k < 8; k++) begin
      if (r_col >= CNT_W'(k * BAR_W)) begin
        w_bar_idx = 3'(k);
      end
    end
    w_rgb = 3'b000;
    case (r_pattern)
      PAT_RED:   w_rgb = 3'b100;
      PAT_GREEN: w_rgb = 3'b010;
      PAT_BLUE:  w_rgb = 3'b001;
      PAT_CHECK: w_rgb = {3{r_col[CHECK_SHIFT] ^ r_row[CHECK_SHIFT]}};
      PAT_BARS: begin
        case (w_bar_idx)
          3'd0:    w_rgb = 3'b111;
          3'd1:    w_rgb = 3'b110;
          3'd2:    w_rgb = 3'b011;
          3'd3:    w_rgb = 3'b010;
          3'd4:    w_rgb = 3'b101;
          3'd5:    w_rgb = 3'b100;
          3'd6:    w_rgb = 3'b001;
          default: w_rgb = 3'b000;
        endcase
      end
      PAT_BORDER: begin
        if ((r_col == '0) || (r_col == LP_LAST_ACT_COL) ||
            (r_row == '0) || (r_row == LP_LAST_ACT_ROW)) begin
          w_rgb = 3'b111;
        end
      end
`ifdef TP_MOVING_BAR_EN
      PAT_BAR:   w_rgb = {3{w_bar_hit}};
`endif
      default:   w_rgb = 3'b000;
    endcase
  end

  // Stage 2: active flag and blanked RGB, aligned with the re-timed syncs.
  always_ff @(posedge CLK or posedge RST) begin : p_stage2
    if (RST) begin
      r_active <= 1'b0;
      r_red    <= '0;
      r_grn    <= '0;
      r_blu    <= '0;
    end else begin
      r_active <= w_in_active;
      r_red    <= {VIDEO_WIDTH{w_in_active & w_rgb[2]}};
      r_grn    <= {VIDEO_WIDTH{w_in_active & w_rgb[1]}};
      r_blu    <= {VIDEO_WIDTH{w_in_active & w_rgb[0]}};
    end
  end

  assign o_H_Sync    = r_h_out;
  assign o_V_Sync    = r_v_out;
  assign o_Active    = r_active;
  assign o_Col_Count = r_col;
  assign o_Row_Count = r_row;
  assign o_Red       = r_red;
  assign o_Grn       = r_grn;
  assign o_Blu       = r_blu;

endmodule

// File: tb/tb_sync_to_pattern.sv
// Bench for sync_to_pattern: hand-computed pixel table, directed corner sequences and
// random sync traffic, all checked against a frame-level reference model.
module tb_sync_to_pattern;

  localparam int ACT_C = 640;
  localparam int ACT_R = 480;
  localparam int TOT_C = 800;
  localparam int TOT_R = 525;

  logic       CLK;
  logic       RST;
  logic       i_H_Sync;
  logic       i_V_Sync;
  logic [2:0] i_Pattern;
  logic       o_H_Sync;
  logic       o_V_Sync;
  logic       o_Active;
  logic [9:0] o_Col_Count;
  logic [9:0] o_Row_Count;
  logic [2:0] o_Red;
  logic [2:0] o_Grn;
  logic [2:0] o_Blu;

  sync_to_pattern dut (
    .CLK(CLK), .RST(RST),
    .i_H_Sync(i_H_Sync), .i_V_Sync(i_V_Sync), .i_Pattern(i_Pattern),
    .o_H_Sync(o_H_Sync), .o_V_Sync(o_V_Sync), .o_Active(o_Active),
    .o_Col_Count(o_Col_Count), .o_Row_Count(o_Row_Count),
    .o_Red(o_Red), .o_Grn(o_Grn), .o_Blu(o_Blu)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state
  int   m_col, m_row, m_pat, m_vcount;
  logic m_hprev, m_vprev;
  int   e_oh, e_ov, e_act, e_r, e_g, e_b;
  int   bar_lut [8] = '{7, 6, 3, 2, 5, 4, 1, 0};

  typedef struct {
    logic [2:0] pat;
    int row;
    int col;
    int act;
    int r;
    int g;
    int b;
  } vec_t;

  vec_t tbl [$];

  function automatic logic [31:0] pack(int oh, int ov, int act, int col, int row, int r, int g, int b);
    return {1'(oh), 1'(ov), 1'(act), 10'(col), 10'(row), 3'(r), 3'(g), 3'(b)};
  endfunction

  function automatic logic [31:0] dut_now();
    return {o_H_Sync, o_V_Sync, o_Active, o_Col_Count, o_Row_Count, o_Red, o_Grn, o_Blu};
  endfunction

  function automatic logic [31:0] dut_pix();
    return {22'd0, o_Active, o_Red, o_Grn, o_Blu};
  endfunction

  function automatic logic [31:0] pix(int act, int r, int g, int b);
    return {22'd0, 1'(act), 3'(r), 3'(g), 3'(b)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Colour mask {R,G,B} for a visible pixel.
  function automatic int pix_mask(int p, int c, int r, int bar);
    case (p)
      1: return 4;
      2: return 2;
      3: return 1;
      4: return (((c / 32) + (r / 32)) % 2 == 1) ? 7 : 0;
      5: return bar_lut[c / (ACT_C / 8)];
      6: return (c == 0 || c == ACT_C - 1 || r == 0 || r == ACT_R - 1) ? 7 : 0;
`ifdef TP_MOVING_BAR_EN
      7: return (c >= bar && c < bar + 8) ? 7 : 0;
`endif
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_col = 0; m_row = 0; m_pat = 0; m_vcount = 0;
    m_hprev = 1'b1; m_vprev = 1'b1;
  endtask

  task automatic model_step(input logic h, input logic v, input logic [2:0] p);
    int  mask;
    bit  he, ve, line_start;
    e_act = (m_col < ACT_C && m_row < ACT_R) ? 1 : 0;
    mask  = (e_act == 1) ? pix_mask(m_pat, m_col, m_row, (m_vcount * 8) % ACT_C) : 0;
    e_r   = ((mask / 4) % 2 == 1) ? 7 : 0;
    e_g   = ((mask / 2) % 2 == 1) ? 7 : 0;
    e_b   = (mask % 2 == 1) ? 7 : 0;
    e_oh  = int'(m_hprev);
    e_ov  = int'(m_vprev);
    he = h && !m_hprev;
    ve = v && !m_vprev;
    line_start = he || (m_col == TOT_C - 1);
    m_col = line_start ? 0 : m_col + 1;
    if (ve) m_row = 0;
    else if (line_start) m_row = (m_row + 1) % TOT_R;
    if (ve) begin
      m_pat = int'(p);
      m_vcount++;
    end
    m_hprev = h;
    m_vprev = v;
  endtask

  // One pixel clock: drive at the falling edge, sample just after the rising edge.
  task automatic tick(input logic h, input logic v, input logic [2:0] p);
    i_H_Sync  = h;
    i_V_Sync  = v;
    i_Pattern = p;
    @(posedge CLK);
    #1;
    model_step(h, v, p);
    check("model", dut_now(), pack(e_oh, e_ov, e_act, m_col, m_row, e_r, e_g, e_b));
    @(negedge CLK);
  endtask

  // Lock to a frame start, then walk to (row, col) and present that pixel.
  task automatic goto_pixel(input logic [2:0] p, input int row, input int col);
    tick(1'b0, 1'b0, p);
    tick(1'b1, 1'b1, p);
    for (int i = 0; i < row; i++) begin
      tick(1'b0, 1'b1, p);
      tick(1'b1, 1'b1, p);
    end
    for (int i = 0; i < col; i++) tick(1'b1, 1'b1, p);
    tick(1'b1, 1'b1, p);
  endtask

  initial begin
    int   red_cnt, blank_cnt;
    int   prev_col, prev_row;
    bit   wrap_seen, any_x;

    tbl.push_back('{3'd1,   5, 100, 1, 7, 0, 0});
    tbl.push_back('{3'd1,   5, 639, 1, 7, 0, 0});
    tbl.push_back('{3'd1,   5, 640, 0, 0, 0, 0});
    tbl.push_back('{3'd2,   0,   0, 1, 0, 7, 0});
    tbl.push_back('{3'd3, 479,  10, 1, 0, 0, 7});
    tbl.push_back('{3'd3, 480,  10, 0, 0, 0, 0});
    tbl.push_back('{3'd4,   0,  31, 1, 0, 0, 0});
    tbl.push_back('{3'd4,   0,  32, 1, 7, 7, 7});
    tbl.push_back('{3'd4,  32,  32, 1, 0, 0, 0});
    tbl.push_back('{3'd4,  32,   0, 1, 7, 7, 7});
    tbl.push_back('{3'd5,  10,  79, 1, 7, 7, 7});
    tbl.push_back('{3'd5,  10,  80, 1, 7, 7, 0});
    tbl.push_back('{3'd5,  10, 160, 1, 0, 7, 7});
    tbl.push_back('{3'd5,  10, 559, 1, 0, 0, 7});
    tbl.push_back('{3'd5,  10, 560, 1, 0, 0, 0});
    tbl.push_back('{3'd6,   0,   5, 1, 7, 7, 7});
    tbl.push_back('{3'd6,   5,   0, 1, 7, 7, 7});
    tbl.push_back('{3'd6,   5, 639, 1, 7, 7, 7});
    tbl.push_back('{3'd6,   5,   5, 1, 0, 0, 0});
    tbl.push_back('{3'd6, 479, 300, 1, 7, 7, 7});
`ifndef TP_MOVING_BAR_EN
    tbl.push_back('{3'd7,   5,   5, 1, 0, 0, 0});
`endif

    RST = 1'b1; i_H_Sync = 1'b1; i_V_Sync = 1'b1; i_Pattern = 3'd0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    check("reset", dut_now(), pack(1, 1, 0, 0, 0, 0, 0, 0));
    @(negedge CLK);
    RST = 1'b0;

    // 640-high / 160-low lines, red pattern
    red_cnt = 0; blank_cnt = 0;
    tick(1'b0, 1'b0, 3'd1);
    for (int t = 0; t <= 2400; t++) begin
      tick(((t % TOT_C) < ACT_C) ? 1'b1 : 1'b0, 1'b1, 3'd1);
      if (t >= 1) begin
        if (o_Active && o_Red == 3'd7 && o_Grn == 3'd0 && o_Blu == 3'd0) red_cnt++;
        if (!o_Active && o_Red == 3'd0 && o_Grn == 3'd0 && o_Blu == 3'd0) blank_cnt++;
      end
      if (t == 800) check("hsync_lag1", 32'(o_H_Sync), 32'd0);
      if (t == 801) check("hsync_lag2", 32'(o_H_Sync), 32'd1);
    end
    check("red_cycles", 32'(red_cnt), 32'd1920);
    check("blank_cycles", 32'(blank_cnt), 32'd480);

    foreach (tbl[i]) begin
      goto_pixel(tbl[i].pat, tbl[i].row, tbl[i].col);
      check($sformatf("tbl%0d_p%0d_r%0d_c%0d", i, tbl[i].pat, tbl[i].row, tbl[i].col),
            dut_pix(), pix(tbl[i].act, tbl[i].r, tbl[i].g, tbl[i].b));
    end

    // Pattern select changed mid-frame only takes effect at the next frame
    tick(1'b0, 1'b0, 3'd1);
    tick(1'b1, 1'b1, 3'd1);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 3'd2);
      tick(1'b1, 1'b1, 3'd2);
    end
    repeat (50) tick(1'b1, 1'b1, 3'd2);
    check("keep_red", dut_pix(), pix(1, 7, 0, 0));
    tick(1'b0, 1'b0, 3'd2);
    tick(1'b1, 1'b1, 3'd2);
    tick(1'b1, 1'b1, 3'd2);
    check("new_green", dut_pix(), pix(1, 0, 7, 0));

    // Syncs stuck high: counters must free-run and wrap
    tick(1'b0, 1'b0, 3'd3);
    tick(1'b1, 1'b1, 3'd3);
    wrap_seen = 1'b0; any_x = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      prev_col = int'(o_Col_Count);
      prev_row = int'(o_Row_Count);
      tick(1'b1, 1'b1, 3'd3);
      if ($isunknown(dut_now())) any_x = 1'b1;
      if (prev_col == TOT_C - 1) begin
        wrap_seen = 1'b1;
        check("col_wrap", {22'd0, o_Col_Count}, 32'd0);
        check("row_step", {22'd0, o_Row_Count}, 32'((prev_row + 1) % TOT_R));
      end
    end
    check("wrap_seen", 32'(wrap_seen), 32'd1);
    check("no_x", 32'(any_x), 32'd0);

    // Asynchronous reset mid-frame
    #2 RST = 1'b1;
    #1 check("async_reset", dut_now(), pack(1, 1, 0, 0, 0, 0, 0, 0));
    @(posedge CLK);
    #1 check("held_reset", dut_now(), pack(1, 1, 0, 0, 0, 0, 0, 0));
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    repeat (5) tick(1'b1, 1'b1, 3'd5);

    // Random sync traffic with glitches and pattern changes
    begin
      int L, hh, hc, lines, vper;
      logic [2:0] p;
      L = 20; hh = 12; hc = 0; lines = 0; vper = 10; p = 3'd0;
      for (int n = 0; n < 8000; n++) begin
        logic h, v;
        h = (hc < hh) ? 1'b1 : 1'b0;
        v = (lines != 0) ? 1'b1 : 1'b0;
        if ($urandom_range(0, 49) == 0) h = ~h;
        if ($urandom_range(0, 99) == 0) p = 3'($urandom_range(0, 7));
        tick(h, v, p);
        hc++;
        if (hc >= L) begin
          hc = 0;
          lines = (lines + 1) % vper;
          if (lines == 0) vper = int'($urandom_range(2, 40));
          L  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(100, 900)) : int'($urandom_range(4, 40));
          hh = int'($urandom_range(1, L - 1));
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
